// File: rtl/fp_issue_scoreboard.sv
// FP issue/hazard scoreboard: PIPE_LAT-deep writer tracker plus iterative div/sqrt counter.
// Combinational stall/forward/write-back decode; define FP_SB_DIV_EN to enable the iterative divider path.
module fp_issue_scoreboard #(
  parameter int NREG     = 32,
  parameter int PIPE_LAT = 3,
  parameter int DIV_LAT  = 16,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_cancel,
  input  logic          ext_stall,
  input  logic [2:0]    id_op,
  input  logic [AW-1:0] id_fs,
  input  logic [AW-1:0] id_ft,
  input  logic [AW-1:0] id_fd,
  input  logic          id_use_fs,
  input  logic          id_use_ft,
  output logic          stall,
  output logic          issue,
  output logic [1:0]    fwd_fs,
  output logic [1:0]    fwd_ft,
  output logic [2:0]    pipe_fc,
  output logic          div_start,
  output logic          div_busy,
  output logic          wb_en,
  output logic [AW-1:0] wb_rn,
  output logic          wb_sel,
  output logic [31:0]   stall_cnt
);

  localparam int CW = $clog2(DIV_LAT + 1);

`ifdef FP_SB_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic [PIPE_LAT:1] pv;
  logic [AW-1:0]     prn [1:PIPE_LAT];
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     drn;
  logic [31:0]       stall_cnt_q;

  logic is_div, pipelined, req, div_active, div_last;
  logic hz_pipe, hz_div, hz_struct, hz_coll, hz_waw;

  assign is_div     = DIV_EN && id_op[2];
  assign pipelined  = ~is_div;
  assign req        = id_valid & ~id_cancel;
  assign div_active = (cnt > CW'(1));
  assign div_last   = (cnt == CW'(1));
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    hz_pipe = 1'b0;
    // the last stage is excluded: it is forwarded instead of stalled on
    for (int k = 1; k < PIPE_LAT; k++) begin
      if (pv[k] && ((id_use_fs && prn[k] == id_fs) || (id_use_ft && prn[k] == id_ft)))
        hz_pipe = 1'b1;
    end
    hz_div    = div_active && ((id_use_fs && drn == id_fs) || (id_use_ft && drn == id_ft));
    hz_struct = is_div && div_active;
    // a pipelined op issued now would land on the divider's write-back cycle
    hz_coll   = pipelined && (cnt == CW'(PIPE_LAT + 1));
    hz_waw    = pipelined && div_active && (id_fd == drn);
    stall     = req & (hz_pipe | hz_div | hz_struct | hz_coll | hz_waw);
    issue     = req & ~stall & ~ext_stall;
    pipe_fc   = (issue && pipelined) ? id_op : 3'b000;
    div_start = issue & is_div;
    div_busy  = (cnt != '0);
  end

  always_comb begin
    fwd_fs = 2'b00;
    fwd_ft = 2'b00;
    if (req && !stall) begin
      if (id_use_fs) begin
        if (pv[PIPE_LAT] && prn[PIPE_LAT] == id_fs) fwd_fs = 2'b01;
        else if (div_last && drn == id_fs)         fwd_fs = 2'b10;
      end
      if (id_use_ft) begin
        if (pv[PIPE_LAT] && prn[PIPE_LAT] == id_ft) fwd_ft = 2'b01;
        else if (div_last && drn == id_ft)         fwd_ft = 2'b10;
      end
    end
  end

  always_comb begin
    wb_en  = 1'b0;
    wb_sel = 1'b0;
    wb_rn  = '0;
    if (pv[PIPE_LAT]) begin
      wb_en = 1'b1;
      wb_rn = prn[PIPE_LAT];
    end else if (div_last) begin
      wb_en  = 1'b1;
      wb_sel = 1'b1;
      wb_rn  = drn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv          <= '0;
      cnt         <= '0;
      drn         <= '0;
      stall_cnt_q <= '0;
      for (int k = 1; k <= PIPE_LAT; k++) prn[k] <= '0;
    end else begin
      pv     <= {pv[PIPE_LAT-1:1], issue & pipelined};
      prn[1] <= id_fd;
      for (int k = 2; k <= PIPE_LAT; k++) prn[k] <= prn[k-1];
      if (div_start) begin
        cnt <= CW'(DIV_LAT);
        drn <= id_fd;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
